hello_scroll_ctrl: RTL

//  Sequencer that drives the 4-bit step index of the HAPPY 7-seg scroll decoder.
//  It replaces the manual SW[3:0] input with a timed, auto-advancing index.
//  It supports loop and one-shot modes, forward and reverse direction, pause, and single-step.
//  It sits between the board inputs (already debounced and edge-detected) and the display decoder.

---
 rtl/hello_scroll_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/hello_scroll_ctrl.sv
// Timed step-index sequencer for the HAPPY 7-seg scroll decoder.
// Supports loop/one-shot, forward/reverse, pause and single-step operation.
module hello_scroll_ctrl #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned CNT_W     = 26,
    parameter int unsigned LAST_STEP = 9
) (
    input  logic       CLOCK_50,
    input  logic       RST,
    input  logic       START,
    input  logic       STOP,
    input  logic       PAUSE,
    input  logic       STEP_REQ,
    input  logic       DIR,
    input  logic       MODE,
    output logic [3:0] STEP,
    output logic       BUSY,
    output logic       TICK,
    output logic       DONE
);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

    localparam logic [CNT_W-1:0] CntLast  = CNT_W'(TICK_DIV - 1);
    localparam logic [3:0]       StepLast = 4'(LAST_STEP);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       step_q, step_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;

    logic             wrap;
    logic             adv;
    logic [3:0]       step_adv;

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            step_q  <= '0;
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    // One-shot wrap always lands on 0; loop wrap lands on the far end for the current direction.
    always_comb begin
        wrap = DIR ? (step_q == 4'd0) : (step_q == StepLast);
        if (wrap) begin
            step_adv = (DIR && !mode_q) ? StepLast : 4'd0;
        end else begin
            step_adv = DIR ? (step_q - 4'd1) : (step_q + 4'd1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        adv     = 1'b0;
        if (STOP) begin
            state_d = StIdle;
            cnt_d   = '0;
            step_d  = '0;
        end else if (START) begin
            state_d = StRun;
            cnt_d   = '0;
            mode_d  = MODE;
            step_d  = DIR ? StepLast : 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d  = '0;
                    step_d = '0;
                end
                StRun: begin
                    if (PAUSE) begin
                        state_d = StPause;
                    end else if (cnt_q == CntLast) begin
                        cnt_d = '0;
                        adv   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StPause: begin
                    if (!PAUSE) begin
                        state_d = StRun;
                    end
                    adv = STEP_REQ;
                end
                default: state_d = StIdle;
            endcase
            if (adv) begin
                step_d = step_adv;
                tick_d = 1'b1;
                if (wrap && mode_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        STEP = step_q;
        BUSY = (state_q != StIdle);
        TICK = tick_q;
        DONE = done_q;
    end

endmodule
